// File: rtl/uart_seq_pkg.sv
// uart_seq_trig shared types and helpers.
// Byte hit rule, FSM states and gap counter width.
package uart_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MATCH = 1'b1
  } seq_state_t;

  localparam int GAP_W = 16;

  // A byte hits when all unmasked bits agree.
  function automatic logic byte_hit(
    input logic [7:0] data,
    input logic [7:0] match,
    input logic [7:0] mask
  );
    return (data | mask) == (match | mask);
  endfunction

endpackage

// File: rtl/uart_seq_trig_rx.sv
// UART_rx_cfg_baud: 8N1 receiver with run-time baud divisor.
// rdy holds until clr_rdy; bad stop bit drops the frame.
module UART_rx_cfg_baud (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic [15:0] baud,
  input  logic        clr_rdy,
  output logic [7:0]  rx_data,
  output logic        rdy
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t   r_state;
  logic        r_s1;
  logic        r_s2;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [16:0] w_cnt_nx;
  logic        w_half;
  logic        w_full;

  assign w_cnt_nx = {1'b0, r_cnt} + 17'd1;
  assign w_half   = w_cnt_nx >= {2'b0, baud[15:1]};
  assign w_full   = w_cnt_nx >= {1'b0, baud};

  // Two-flop synchroniser for the async serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= RX;
      r_s2 <= r_s1;
    end
  end

  // Frame FSM: mid-bit sampling, data LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      rx_data <= '0;
      rdy     <= 1'b0;
    end else begin
      if (clr_rdy) rdy <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!r_s2) r_state <= RX_START;
        end
        RX_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_state <= r_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= w_cnt_nx[15:0];
          end
        end
        RX_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {r_s2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= w_cnt_nx[15:0];
          end
        end
        RX_STOP: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_s2) begin
              rx_data <= r_shift;
              rdy     <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_nx[15:0];
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_seq_trig.sv
// Multi-byte UART sequence trigger over UART_rx_cfg_baud.
// Macro UART_SEQ_GAP_TIMEOUT_EN builds the inter-byte timeout.
import uart_seq_pkg::*;

module uart_seq_trig #(
  parameter int SEQ_LEN = 4,
  parameter int BAUD_W  = 16,
  parameter int IDX_W   = $clog2(SEQ_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RX,
  input  logic [BAUD_W-1:0]      baud_cnt,
  input  logic [SEQ_LEN*8-1:0]   match,
  input  logic [SEQ_LEN*8-1:0]   mask,
  input  logic [IDX_W-1:0]       seq_len,
  input  logic [GAP_W-1:0]       gap_limit,
  output logic                   UARTtrig,
  output logic [IDX_W-1:0]       seq_idx,
  output logic                   gap_to
);

  logic [15:0]      w_baud;
  logic [7:0]       w_rx_data;
  logic             w_rdy;
  logic             r_clr_rdy;
  logic             w_consume;
  seq_state_t       r_state;
  logic [IDX_W-1:0] r_seq_idx;
  logic             r_trig;
  logic             r_gap_to;
  logic [IDX_W-1:0] w_eff;
  logic             w_to;
  logic             w_force;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_nxt;
  logic [7:0]       w_m_cur;
  logic [7:0]       w_k_cur;
  logic             w_hit_cur;
  logic             w_hit_0;
  logic             w_last;
  logic             w_one;
  logic             w_fire;
  logic             w_adv;
  logic             w_rest;

  assign w_baud = 16'(baud_cnt);

  UART_rx_cfg_baud u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .baud    (w_baud),
    .clr_rdy (r_clr_rdy),
    .rx_data (w_rx_data),
    .rdy     (w_rdy)
  );

  assign w_consume = w_rdy & ~r_clr_rdy;

  // Acknowledge a ready byte one cycle after it appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clr_rdy <= 1'b0;
    else        r_clr_rdy <= w_rdy & ~r_clr_rdy;
  end

  // Effective length: 0 acts as 1, oversize clamps.
  always_comb begin
    w_eff = seq_len;
    if (seq_len == '0)
      w_eff = IDX_W'(1);
    else if (seq_len > IDX_W'(SEQ_LEN))
      w_eff = IDX_W'(SEQ_LEN);
  end

`ifdef UART_SEQ_GAP_TIMEOUT_EN
  logic [GAP_W-1:0] r_gap_cnt;

  assign w_to = (gap_limit != '0) &&
                (r_gap_cnt == gap_limit) &&
                (r_state == MATCH);

  // Inter-byte idle counter, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_gap_cnt <= '0;
    else if (w_consume)
      r_gap_cnt <= '0;
    else if (r_state == MATCH && r_gap_cnt != '1)
      r_gap_cnt <= r_gap_cnt + 1'b1;
  end
`else
  logic w_unused_gap;
  assign w_unused_gap = ^gap_limit;
  assign w_to = 1'b0;
`endif

  // Progress is dropped on timeout or a shrunken length.
  assign w_force = (r_state == IDLE) || w_to ||
                   (r_seq_idx >= w_eff);
  assign w_start = w_force ? '0 : r_seq_idx;
  assign w_nxt   = w_start + IDX_W'(1);

  // Pattern byte for the current position.
  always_comb begin
    w_m_cur = match[7:0];
    w_k_cur = mask[7:0];
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (IDX_W'(i) == w_start) begin
        w_m_cur = match[i*8 +: 8];
        w_k_cur = mask[i*8 +: 8];
      end
    end
  end

  assign w_hit_cur = byte_hit(w_rx_data, w_m_cur, w_k_cur);
  assign w_hit_0   = byte_hit(w_rx_data, match[7:0], mask[7:0]);
  assign w_last    = (w_nxt == w_eff);
  assign w_one     = (w_eff == IDX_W'(1));
  assign w_fire    = (w_hit_cur && w_last) ||
                     (!w_hit_cur && w_hit_0 && w_one);
  assign w_adv     = w_hit_cur && !w_last;
  assign w_rest    = !w_hit_cur && w_hit_0 && !w_one;

  // Sequence FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_seq_idx <= '0;
      r_trig    <= 1'b0;
      r_gap_to  <= 1'b0;
    end else begin
      r_trig   <= 1'b0;
      r_gap_to <= w_to;
      if (w_consume) begin
        unique case (1'b1)
          w_fire: begin
            r_trig    <= 1'b1;
            r_seq_idx <= '0;
            r_state   <= IDLE;
          end
          w_adv: begin
            r_seq_idx <= w_nxt;
            r_state   <= MATCH;
          end
          w_rest: begin
            r_seq_idx <= IDX_W'(1);
            r_state   <= MATCH;
          end
          default: begin
            r_seq_idx <= '0;
            r_state   <= IDLE;
          end
        endcase
      end else if (w_force) begin
        r_seq_idx <= '0;
        r_state   <= IDLE;
      end
    end
  end

  assign UARTtrig = r_trig;
  assign seq_idx  = r_seq_idx;
  assign gap_to   = r_gap_to;

endmodule

// File: tb/tb_uart_seq_trig.sv
// Bench for uart_seq_trig: table vectors, corner
// sequences and random bytes against a byte-level model.
module tb_uart_seq_trig;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [15:0] baud_cnt = 16'(BAUD);
  logic [31:0] match = '0;
  logic [31:0] mask = '0;
  logic [2:0]  seq_len = 3'd1;
  logic [15:0] gap_limit = '0;
  logic        UARTtrig;
  logic [2:0]  seq_idx;
  logic        gap_to;

  int checks = 0;
  int errors = 0;
  int trig_cnt = 0;
  int gto_cnt = 0;
  int mdl_idx = 0;
  int mdl_trig = 0;
  logic rdy_d1 = 1'b0;
  logic rdy_d2 = 1'b0;
  logic trig_d1 = 1'b0;

  uart_seq_trig dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .baud_cnt  (baud_cnt),
    .match     (match),
    .mask      (mask),
    .seq_len   (seq_len),
    .gap_limit (gap_limit),
    .UARTtrig  (UARTtrig),
    .seq_idx   (seq_idx),
    .gap_to    (gap_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Pulse monitor: width and latency after rdy rises.
  always @(negedge clk) begin
    if (UARTtrig) begin
      trig_cnt++;
      checks++;
      if (!(rdy_d1 && !rdy_d2) || trig_d1) begin
        errors++;
        $display("FAIL trig_timing: rdy %0d%0d prev_trig %0d",
                 rdy_d2, rdy_d1, trig_d1);
      end
    end
    if (gap_to) gto_cnt++;
    trig_d1 = UARTtrig;
    rdy_d2  = rdy_d1;
    rdy_d1  = dut.w_rdy;
  end

  function automatic bit mhit(input logic [7:0] d,
                              input int i);
    logic [7:0] m;
    logic [7:0] k;
    m = match[i*8 +: 8];
    k = mask[i*8 +: 8];
    return (d | k) == (m | k);
  endfunction

  // Byte-level reference: advance, or restart at byte 0.
  function automatic void model_byte(input logic [7:0] d);
    int eff;
    eff = (seq_len == 0) ? 1 :
          ((seq_len > 4) ? 4 : int'(seq_len));
    if (mdl_idx >= eff) mdl_idx = 0;
    if (mhit(d, mdl_idx)) begin
      if (mdl_idx + 1 == eff) begin
        mdl_trig++;
        mdl_idx = 0;
      end else begin
        mdl_idx++;
      end
    end else if (mhit(d, 0)) begin
      if (eff == 1) begin
        mdl_trig++;
        mdl_idx = 0;
      end else begin
        mdl_idx = 1;
      end
    end else begin
      mdl_idx = 0;
    end
  endfunction

  task automatic send_frame(input logic [7:0] d,
                            input int nbits);
    logic v;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)      v = 1'b0;
      else if (b == 9) v = 1'b1;
      else             v = d[b-1];
      @(negedge clk) RX = v;
      repeat (BAUD - 1) @(negedge clk);
    end
  endtask

  task automatic send_chk(input logic [7:0] d,
                          input string nm);
    int t0;
    int m0;
    t0 = trig_cnt;
    m0 = mdl_trig;
    model_byte(d);
    send_frame(d, 10);
    @(negedge clk) RX = 1'b1;
    repeat (6) @(negedge clk);
    chk({nm, "_idx"}, int'(seq_idx), mdl_idx);
    chk({nm, "_trig"}, trig_cnt - t0, mdl_trig - m0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mdl_idx = 0;
  endtask

  typedef struct {
    logic [2:0]  len;
    logic [31:0] m;
    logic [31:0] k;
    int          n;
    logic [47:0] b;
    int          exp_trig;
    int          exp_idx;
  } vec_t;

  vec_t vt[10];

  initial begin
    int t0;
    int g0;
    logic [7:0] d;
    int j;

    vt[0] = '{3'd3, 32'h000FAA55, 32'h0, 3,
              48'h0F_AA_55, 1, 0};
    vt[1] = '{3'd3, 32'h000FAA55, 32'h0, 4,
              48'h0F_AA_55_55, 1, 0};
    vt[2] = '{3'd1, 32'h000000A0, 32'h0000000F, 2,
              48'hB0_A7, 1, 0};
    vt[3] = '{3'd0, 32'h000000A0, 32'h0000000F, 2,
              48'hB0_A5, 1, 0};
    vt[4] = '{3'd7, 32'h44332211, 32'h0, 3,
              48'h33_22_11, 0, 3};
    vt[5] = '{3'd7, 32'h44332211, 32'h0, 4,
              48'h44_33_22_11, 1, 0};
    vt[6] = '{3'd4, 32'h44332211, 32'h0, 6,
              48'h44_33_22_11_22_11, 1, 0};
    vt[7] = '{3'd2, 32'h0000BBAA, 32'h0, 4,
              48'hBB_AA_BB_AA, 2, 0};
    vt[8] = '{3'd2, 32'h0000BBAA, 32'h0, 3,
              48'hBB_AA_AA, 1, 0};
    vt[9] = '{3'd4, 32'hF0F0F0F0, 32'h0F0F0F0F, 4,
              48'hFF_F3_F0_FA, 1, 0};

    repeat (2) @(negedge clk);
    chk("rst_trig", int'(UARTtrig), 0);
    chk("rst_idx", int'(seq_idx), 0);
    chk("rst_gapto", int'(gap_to), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      seq_len = vt[v].len;
      match = vt[v].m;
      mask = vt[v].k;
      do_reset();
      t0 = trig_cnt;
      for (int i = 0; i < vt[v].n; i++)
        send_chk(vt[v].b[i*8 +: 8], $sformatf("v%0d_b%0d", v, i));
      chk($sformatf("v%0d_final_idx", v),
          int'(seq_idx), vt[v].exp_idx);
      chk($sformatf("v%0d_total_trig", v),
          trig_cnt - t0, vt[v].exp_trig);
    end

    // Shrinking seq_len below progress drops it.
    seq_len = 3'd3;
    match = 32'h000FAA55;
    mask = '0;
    do_reset();
    send_chk(8'h55, "shr_b0");
    send_chk(8'hAA, "shr_b1");
    @(negedge clk) seq_len = 3'd2;
    repeat (2) @(negedge clk);
    chk("shr_idx", int'(seq_idx), 0);
    mdl_idx = 0;
    seq_len = 3'd3;

    // Reset in the middle of the second byte.
    do_reset();
    send_chk(8'h55, "mrst_b0");
    send_frame(8'hAA, 5);
    rst_n = 1'b0;
    #1;
    chk("mrst_trig", int'(UARTtrig), 0);
    chk("mrst_idx", int'(seq_idx), 0);
    chk("mrst_gapto", int'(gap_to), 0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    mdl_idx = 0;
    t0 = trig_cnt;
    send_chk(8'h55, "mrst_r0");
    send_chk(8'hAA, "mrst_r1");
    send_chk(8'h0F, "mrst_r2");
    chk("mrst_resend", trig_cnt - t0, 1);

    // Idle after a partial match.
    do_reset();
    gap_limit = 16'd100;
    g0 = gto_cnt;
    send_chk(8'h55, "gap_b0");
    repeat (150) @(negedge clk);
`ifdef UART_SEQ_GAP_TIMEOUT_EN
    chk("gap_pulse", gto_cnt - g0, 1);
    chk("gap_idx", int'(seq_idx), 0);
    mdl_idx = 0;
`else
    chk("gap_pulse", gto_cnt - g0, 0);
    chk("gap_idx", int'(seq_idx), 1);
`endif
    gap_limit = '0;
    send_chk(8'hAA, "gap_b1");
    send_chk(8'h0F, "gap_b2");

    // Random patterns and bytes against the model.
    for (int c = 0; c < 6; c++) begin
      seq_len = 3'($urandom_range(0, 7));
      match = $urandom;
      mask = $urandom & $urandom & $urandom;
      for (int i = 0; i < 10; i++) begin
        j = $urandom_range(0, 3);
        d = match[j*8 +: 8];
        if ($urandom_range(0, 3) == 0)
          d = d ^ 8'($urandom);
        send_chk(d, $sformatf("rnd%0d_%0d", c, i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_seq_trig.md
# uart_seq_trig

Multi-byte UART sequence trigger: receives serial bytes on `RX` at a run-time baud divisor and fires a single-cycle `UARTtrig` when up to `SEQ_LEN` consecutive received bytes each match a per-byte match/mask pattern. It is the parametrised successor to the single-byte UART protocol trigger. It sits in the trigger-source bank beside the other serial-protocol triggers and feeds the capture trigger logic.

## Interface
- `SEQ_LEN`, default 4: maximum sequence length in bytes, minimum 1.
- `BAUD_W`, default 16: width of the baud divisor.
- `IDX_W`, derived as `$clog2(SEQ_LEN+1)`: width of the length and index fields.

Ports. One clock; reset is asynchronous and active-low.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `RX` input, 1 bit: serial line, idle high.
- `baud_cnt` input, `BAUD_W` bits: clocks per bit.
- `match` input, `SEQ_LEN*8` bits: expected bytes; byte *i* is `match[8i+7:8i]`, and byte 0 is received first.
- `mask` input, `SEQ_LEN*8` bits: per-bit don't-care mask, where 1 means the bit is ignored.
- `seq_len` input, `IDX_W` bits: active sequence length. 0 is treated as 1; values greater than `SEQ_LEN` are clamped to `SEQ_LEN`.
- `gap_limit` input, 16 bits: inter-byte timeout in clocks; 0 disables the timeout.
- `UARTtrig` output, 1 bit: one-cycle trigger pulse.
- `seq_idx` output, `IDX_W` bits: number of bytes matched so far.
- `gap_to` output, 1 bit: one-cycle pulse when a partial match is discarded by timeout.

## Operation
- The receiver presents `rx_data` and `rdy`. A byte is consumed exactly once, in the first cycle `rdy` is high. `clr_rdy` is registered and asserts in the cycle after `rdy`.
- Byte hit rule: byte *i* hits when `(rx_data | mask_i) == (match_i | mask_i)`.
- FSM states:
  - `IDLE`: `seq_idx` is 0.
  - `MATCH`: 0 < `seq_idx` < effective length.
- FSM transitions, evaluated per consumed byte at `seq_idx`:
  - Hit, and `seq_idx+1` equals the effective length: pulse `UARTtrig`, set `seq_idx` to 0, go to `IDLE`.
  - Hit otherwise: increment `seq_idx`, go to `MATCH`.
  - Miss: re-evaluate the same byte against byte 0. A hit there sets `seq_idx` to 1 (or triggers when the effective length is 1); a miss there sets `seq_idx` to 0. This is a simple restart with no overlap search beyond byte 0.
- `match`, `mask` and `seq_len` are sampled at each evaluation. Changing them mid-sequence does not reset progress.
- If `seq_len` changes so that `seq_idx` is greater than or equal to the new effective length, `seq_idx` is forced to 0 on the next cycle.

## Timing
- Reset values: `UARTtrig` 0, `seq_idx` 0, `gap_to` 0, `clr_rdy` 0, gap counter 0, FSM in `IDLE`. The receiver is reset at the same time.
- Reset asserted mid-frame or mid-sequence aborts all progress immediately.
- Latency: `UARTtrig` is registered and goes high for exactly 1 cycle, in the cycle after `rdy` rises for the final byte.
- `seq_idx` updates in the same cycle as `UARTtrig`.
- Back-to-back full sequences each produce their own pulse.

## Configuration
- Macro `UART_SEQ_GAP_TIMEOUT_EN`.
- Defined:
  - A 16-bit gap counter clears on every consumed byte and counts while in `MATCH`.
  - When the counter equals `gap_limit` (with `gap_limit` nonzero), `seq_idx` is set to 0 and `gap_to` pulses for 1 cycle.
  - If the timeout and a byte consumption land in the same cycle, the timeout is applied first and the byte is evaluated against byte 0.
  - The counter saturates at 0xFFFF.
- Undefined: no counter is built, `gap_to` is tied to 0, and `gap_limit` is ignored.

## Structure
- Package `uart_seq_pkg` holds:
  - The state enum `seq_state_t` with values `IDLE` and `MATCH`.
  - The constant `GAP_W` = 16.
  - The function `byte_hit(data, match, mask)`.
- Sub-module: the existing `UART_rx_cfg_baud` receiver, instantiated unchanged, with `baud_cnt` zero-extended or truncated to its width.
- Sequencing, the gap counter and `clr_rdy` generation live in the top module.

## Test plan
- `SEQ_LEN`=4, `seq_len`=3, match bytes 0x55, 0xAA, 0x0F, mask all 0, send 0x55 0xAA 0x0F → exactly one `UARTtrig` pulse, 1 cycle after the third `rdy`; `seq_idx` runs 1, 2, 0.
- Same pattern, send 0x55 0x55 0xAA 0x0F → the second 0x55 restarts to `seq_idx`=1; trigger after 0x0F.
- `seq_len`=1, match 0xA0, mask 0x0F, send 0xA7 then 0xB0 → trigger on 0xA7 only.
- Macro on, `gap_limit`=100, `baud_cnt`=16, send 0x55 then idle for more than 100 clocks → `gap_to` pulses, `seq_idx` returns to 0, a following 0xAA 0x0F does not trigger.
- `rst_n` asserted halfway through the second byte of a sequence → all outputs 0; resending the full sequence after release triggers normally.
- `seq_len`=0 and `seq_len`=7 (clamped to 4) → they behave as lengths 1 and 4 respectively.
